uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmitter for the UART block: the transmit-side counterpart of the RX edge/bit counting path.
- Accepts one parallel byte through a valid/busy handshake.
- Serialises it LSB-first as start bit, data bits, optional parity bit and stop bit on tx_out.
- clk is the TX baud clock from the system clock divider, so one frame bit is driven per clk cycle (no oversampling on TX).

Parameters:
DATA_WIDTH, 8, number of data bits per frame
IDLE_LEVEL, 1'b1, line level when idle and for the stop bit

Ports:
clk  input  1  TX baud clock; all logic on rising edge
rst  input  1  synchronous active-low reset, sampled on rising edge of clk
p_data  input  DATA_WIDTH  parallel byte to send
data_valid  input  1  request; p_data/par_en/par_typ sampled when data_valid=1 and busy=0
par_en  input  1  1 = append parity bit
par_typ  input  1  0 = even parity, 1 = odd parity
tx_out  output  1  serial line, registered
busy  output  1  registered; 1 while a frame is in progress

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE, tx_out=IDLE_LEVEL, busy=0, shift register and bit counter cleared. Applies mid-frame: the frame is abandoned and the line returns high after that edge; no partial stop bit is added.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is one-hot or binary (designer's choice), defined in the package.
- IDLE: tx_out=1, busy=0. Acceptance happens at edge k when data_valid=1.
  - Latch p_data, par_en and par_typ.
  - Compute parity = ^p_data XOR par_typ.
  - Go to START.
  - After edge k: tx_out=0, busy=1.
- START lasts 1 cycle. Then DATA; after edge k+1, tx_out=p_data[0].
- DATA lasts DATA_WIDTH cycles.
  - After edge k+i, tx_out=data bit i-1, for i=1..DATA_WIDTH.
  - 4-bit bit counter counts 0..DATA_WIDTH-1.
  - On the last bit: go to PARITY if latched par_en=1, else STOP.
- PARITY lasts 1 cycle; tx_out=latched parity bit.
- STOP lasts 1 cycle; tx_out=1.
  - At the next edge: state IDLE, busy=0, tx_out stays 1.
- Frame length: 1+DATA_WIDTH+par_en+1 cycles (10 or 11 with defaults). busy is high for exactly that many cycles.
- Minimum spacing between acceptances is frame length +1 cycle, so at least one idle-high cycle separates frames.
- data_valid while busy=1: ignored, not queued. Upstream must hold the request until busy=0.
- Inputs other than data_valid/rst are don't-care while busy=1. Changes to them do not affect the frame in flight.
- Parity rule: even parity makes the total number of 1s in data+parity even; odd makes it odd. Computed on the latched byte.
- tx_out and busy are glitch-free registered outputs; no combinational path from any input to either.

Decomposition:
- Package uart_tx_pkg:
  - State typedef/localparams (IDLE, START, DATA, PARITY, STOP).
  - PAR_EVEN=0, PAR_ODD=1.
  - START_BIT=0, STOP_BIT=1.
- One sub-module, uart_tx_serializer: load-able DATA_WIDTH shift register plus bit counter.
  - Inputs: load, shift.
  - Outputs: ser_bit, ser_done (asserted during last bit).
- Top: uart_tx_frame holds the FSM, parity register and output mux/register.

Test Plan:
- Reset then idle 5 cycles -> tx_out=1, busy=0 every cycle; toggling data_valid with rst=0 changes nothing.
- p_data=0xA5, par_en=0, one-cycle data_valid -> tx_out sequence 0,1,0,1,0,0,1,0,1,1 (10 cycles); busy=1 for exactly those 10 cycles, then 0.
- p_data=0xA5, par_en=1, par_typ=0 -> parity bit 0, 11-cycle frame. Repeat with par_typ=1 -> parity bit 1.
- p_data=0x01, par_en=1, par_typ=0 -> parity bit 1. With 0x00/odd -> parity bit 1.
- data_valid held high continuously with alternating 0x55/0xAA -> frames back-to-back with exactly one idle-high cycle between them. Bytes that change mid-frame are not transmitted.
- Assert rst=0 for one cycle during data bit 3 of 0xFF -> tx_out=1, busy=0 after that edge. The next data_valid with 0x3C produces a clean full frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame states, parity selectors
// and line-level constants used by the frame FSM and its serializer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Bit counter width; supports frames of up to 16 data bits.
  localparam int CNT_W = 4;

endpackage

// File: rtl/uart_tx_serializer.sv
// Loadable LSB-first shift register with a bit counter that tracks which data
// bit is currently on the line, flagging the last one with ser_done.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_bit,
  output logic                  ser_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  primed_q;

  // The first shift after a load moves bit 0 onto the line, so it arms the
  // counter instead of advancing it; cnt_q then equals the index of the bit
  // being driven.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q  <= '0;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else if (load) begin
      shreg_q  <= load_data;
      cnt_q    <= '0;
      primed_q <= 1'b0;
    end else if (shift) begin
      shreg_q  <= shreg_q >> 1;
      primed_q <= 1'b1;
      if (primed_q) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ser_bit  = shreg_q[0];
  assign ser_done = primed_q && (cnt_q == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: one frame bit per baud-clock cycle, start + data
// (LSB first) + optional parity + stop, with registered tx_out and busy.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  tx_state_e state_q;
  logic      tx_q;
  logic      busy_q;
  logic      par_en_q;
  logic      par_bit_q;

  logic      ser_load;
  logic      ser_shift;
  logic      ser_bit;
  logic      ser_done;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  assign ser_load  = (state_q == ST_IDLE) && data_valid;
  assign ser_shift = (state_q == ST_START) ||
                     ((state_q == ST_DATA) && !ser_done);

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (p_data),
    .ser_bit   (ser_bit),
    .ser_done  (ser_done)
  );

  // tx_q always carries the bit for the state being entered, so the line
  // changes exactly on the edge that changes state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (data_valid) begin
            state_q   <= ST_START;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            par_en_q  <= par_en;
            par_bit_q <= calc_parity(p_data, par_typ);
          end else begin
            tx_q   <= IDLE_LEVEL;
            busy_q <= 1'b0;
          end
        end
        ST_START: begin
          state_q <= ST_DATA;
          tx_q    <= ser_bit;
        end
        ST_DATA: begin
          if (ser_done) begin
            if (par_en_q) begin
              state_q <= ST_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              state_q <= ST_STOP;
              tx_q    <= IDLE_LEVEL;
            end
          end else begin
            tx_q <= ser_bit;
          end
        end
        ST_PARITY: begin
          state_q <= ST_STOP;
          tx_q    <= IDLE_LEVEL;
        end
        ST_STOP: begin
          state_q <= ST_IDLE;
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= IDLE_LEVEL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: directed frames plus randomized traffic
// compared cycle by cycle against a queue-based frame model.
module tb_uart_tx_frame;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          tx_out;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_WIDTH (DW),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  // Reference model: on acceptance the whole frame is queued as a list of line
  // bits; each cycle one bit is consumed, otherwise the line idles high.
  bit mq[$];
  bit m_tx   = 1'b1;
  bit m_busy = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else if (!m_busy && data_valid) begin
      mq.delete();
      mq.push_back(1'b0);
      for (int i = 0; i < DW; i++) mq.push_back(p_data[i]);
      if (par_en) mq.push_back(bit'(($countones(p_data) % 2) ^ int'(par_typ)));
      mq.push_back(1'b1);
      m_tx   = mq.pop_front();
      m_busy = 1'b1;
    end else if (mq.size() > 0) begin
      m_tx   = mq.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check("model_tx", tx_out, m_tx);
    check("model_busy", busy, m_busy);
  endtask

  task automatic run_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                           output logic [15:0] bits, output int len);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    bits       = '1;
    len        = 0;
    cycle();
    data_valid = 1'b0;
    while (busy === 1'b1 && len < 16) begin
      bits[len] = tx_out;
      len++;
      cycle();
    end
  endtask

  logic [15:0] bits;
  int          len;
  int          idle_run;
  bit          seen_frame;

  initial begin
    rst        = 1'b0;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;

    // Held in reset with data_valid toggling: line must stay idle.
    for (int i = 0; i < 5; i++) begin
      data_valid = (i % 2 == 0);
      p_data     = 8'h5A;
      cycle();
      check("rst_tx", tx_out, 1'b1);
      check("rst_busy", busy, 1'b0);
    end
    rst        = 1'b1;
    data_valid = 1'b0;
    cycle();

    run_frame(8'hA5, 1'b0, 1'b0, bits, len);
    check("a5_len", len, 10);
    check("a5_bits", bits[9:0], 10'h34A);

    run_frame(8'hA5, 1'b1, 1'b0, bits, len);
    check("a5_even_len", len, 11);
    check("a5_even_par", bits[9], 1'b0);
    check("a5_even_stop", bits[10], 1'b1);

    run_frame(8'hA5, 1'b1, 1'b1, bits, len);
    check("a5_odd_len", len, 11);
    check("a5_odd_par", bits[9], 1'b1);

    run_frame(8'h01, 1'b1, 1'b0, bits, len);
    check("01_even_par", bits[9], 1'b1);

    run_frame(8'h00, 1'b1, 1'b1, bits, len);
    check("00_odd_par", bits[9], 1'b1);

    // Held request with byte changing every cycle: one idle cycle per gap.
    data_valid = 1'b1;
    par_en     = 1'b0;
    idle_run   = 0;
    seen_frame = 1'b0;
    for (int c = 0; c < 60; c++) begin
      p_data = (c % 2 == 0) ? 8'h55 : 8'hAA;
      cycle();
      if (!busy) begin
        idle_run++;
      end else begin
        if (seen_frame && idle_run > 0) check("b2b_gap", idle_run, 1);
        seen_frame = 1'b1;
        idle_run   = 0;
      end
    end
    data_valid = 1'b0;
    while (busy === 1'b1 && idle_run < 20) begin
      idle_run++;
      cycle();
    end

    // Reset during data bit 3 of 0xFF, then a clean frame.
    p_data     = 8'hFF;
    par_en     = 1'b0;
    data_valid = 1'b1;
    cycle();
    data_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    rst = 1'b0;
    cycle();
    check("midrst_tx", tx_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b1;
    cycle();
    run_frame(8'h3C, 1'b0, 1'b0, bits, len);
    check("3c_len", len, 10);
    check("3c_bits", bits[9:0], {1'b1, 8'h3C, 1'b0});

    // Randomized traffic, including occasional resets and busy-time requests.
    for (int c = 0; c < 3000; c++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      p_data     = DW'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
      rst        = ($urandom_range(0, 199) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
